// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} arb_state_t;
  typedef enum logic {REQ_INSTR, REQ_DATA} req_id_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Everything latched at arbitration except the address, whose width is a top-level parameter.
  typedef struct packed {
    req_id_t     id;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select between fetch and data requests.
// ARB_ROUND_ROBIN_EN: resolve collisions against the last grant instead of DATA_PRIORITY.
module mem_arb_grant #(
  parameter int DATA_PRIORITY = 1
) (
  input  logic instr_req,
  input  logic data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant_data,
`endif
  output logic grant_data
);

  always_comb begin
    grant_data = 1'b0;
    if (instr_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_data = !last_grant_data;
`else
      grant_data = (DATA_PRIORITY != 0);
`endif
    end else if (data_req) begin
      grant_data = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data load/store onto one registered-read RAM port.
// Optional ARB_ROUND_ROBIN_EN swaps fixed priority for alternating grants on collision.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_read,
  input  logic [ADDR_W-1:0] instr_address,
  output logic [31:0]       instr_readdata,
  output logic              instr_waitrequest,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [3:0]        data_byteenable,
  input  logic [31:0]       data_writedata,
  output logic [31:0]       data_readdata,
  output logic              data_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  arb_state_t        state_q, state_d;
  cmd_t              cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       instr_rd_q, data_rd_q;
  logic              data_req, any_req, grant_data, accept;
  logic              ack_instr, ack_data;

  assign data_req = data_read | data_write;
  assign any_req  = instr_read | data_req;
  assign accept   = (state_q == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (reset)       last_grant_q <= 1'b0;
    else if (accept) last_grant_q <= grant_data;
  end
`endif

  mem_arb_grant #(.DATA_PRIORITY(DATA_PRIORITY)) u_grant (
    .instr_req      (instr_read),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant_data(last_grant_q),
`endif
    .data_req       (data_req),
    .grant_data     (grant_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset landing in DONE must not let the requester see a completion.
  assign ack_instr = (state_q == DONE) && (cmd_q.id == REQ_INSTR) && !reset;
  assign ack_data  = (state_q == DONE) && (cmd_q.id == REQ_DATA)  && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      instr_rd_q <= '0;
      data_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (grant_data) begin
          cmd_q.id    <= REQ_DATA;
          cmd_q.wr    <= data_write;
          cmd_q.be    <= data_byteenable;
          cmd_q.wdata <= data_writedata;
          addr_q      <= data_address;
        end else begin
          cmd_q.id    <= REQ_INSTR;
          cmd_q.wr    <= 1'b0;
          cmd_q.be    <= BE_WORD;
          cmd_q.wdata <= '0;
          addr_q      <= instr_address;
        end
      end
      if (ack_instr)              instr_rd_q <= mem_readdata;
      if (ack_data && !cmd_q.wr)  data_rd_q  <= mem_readdata;
    end
  end

  // Address and lanes stay on the pins through DONE since the RAM selects lanes combinationally.
  assign mem_address    = addr_q;
  assign mem_byteenable = cmd_q.be;
  assign mem_writedata  = cmd_q.wdata;
  assign mem_read       = (state_q == ISSUE) && !cmd_q.wr;
  assign mem_write      = (state_q == ISSUE) &&  cmd_q.wr;

  assign instr_waitrequest = !ack_instr;
  assign data_waitrequest  = !ack_data;
  assign instr_readdata    = ack_instr ? mem_readdata : instr_rd_q;
  assign data_readdata     = (ack_data && !cmd_q.wr) ? mem_readdata : data_rd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressed registered-read RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic        data_read, data_write;
  logic [31:0] data_address;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_write, mem_read;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: byte array, word read registered on mem_read, lanes masked by live byteenable.
  logic [7:0]  ram [0:255];
  logic [31:0] rd_word;
  logic [7:0]  ra;
  assign ra = {mem_address[7:2], 2'b00};

  always @(posedge clk) begin
    if (mem_write)
      for (int i = 0; i < 4; i++)
        if (mem_byteenable[i]) ram[ra + 8'(i)] <= mem_writedata[8*i +: 8];
    if (mem_read)
      rd_word <= {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
  end

  always_comb
    for (int i = 0; i < 4; i++)
      mem_readdata[8*i +: 8] = mem_byteenable[i] ? rd_word[8*i +: 8] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One data access; ack expected two cycles after the request is first seen in IDLE.
  task automatic data_acc(input logic wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    data_write = wr; data_read = !wr;
    data_address = a; data_byteenable = be; data_writedata = wd;
    cyc(1);
    chk("data_wait_issue", 32'(data_waitrequest), 32'd1);
    chk("mem_addr_issue", mem_address, a);
    cyc(1);
    chk("data_ack", 32'(data_waitrequest), 32'd0);
    data_write = 1'b0; data_read = 1'b0;
    cyc(1);
  endtask

  task automatic instr_acc(input logic [31:0] a, input logic [31:0] exp);
    instr_read = 1'b1; instr_address = a;
    cyc(1);
    chk("instr_wait_issue", 32'(instr_waitrequest), 32'd1);
    chk("mem_read_issue", 32'(mem_read), 32'd1);
    chk("mem_be_issue", 32'(mem_byteenable), 32'hF);
    cyc(1);
    chk("instr_ack", 32'(instr_waitrequest), 32'd0);
    chk("instr_rdata", instr_readdata, exp);
    chk("mem_be_done", 32'(mem_byteenable), 32'hF);
    chk("mem_read_done", 32'(mem_read), 32'd0);
    instr_read = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic exp_d;
    reset = 1'b1;
    instr_read = 1'b0; instr_address = '0;
    data_read = 1'b0; data_write = 1'b0; data_address = '0;
    data_byteenable = '0; data_writedata = '0;
    cyc(2);
    reset = 1'b0;
    #1;
    chk("rst_instr_wait", 32'(instr_waitrequest), 32'd1);
    chk("rst_data_wait", 32'(data_waitrequest), 32'd1);
    chk("rst_instr_rdata", instr_readdata, 32'h0);
    chk("rst_data_rdata", data_readdata, 32'h0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_be", 32'(mem_byteenable), 32'h0);
    chk("rst_mem_wdata", mem_writedata, 32'h0);

    // Preload through the data port.
    data_acc(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    data_acc(1'b1, 32'h00, 4'hF, 32'h04030201);
    data_acc(1'b1, 32'h30, 4'hF, 32'h44332211);
    chk("ram_10", 32'(ram[8'h10]), 32'hEF);
    chk("ram_13", 32'(ram[8'h13]), 32'hDE);

    instr_acc(32'h10, 32'hDEADBEEF);

    data_acc(1'b1, 32'h20, 4'hF, 32'h12345678);
    data_acc(1'b0, 32'h20, 4'hF, 32'h0);
    chk("load_20", data_readdata, 32'h12345678);
    chk("instr_rdata_hold", instr_readdata, 32'hDEADBEEF);

    // Reset landing in the DONE cycle of a fetch.
    instr_read = 1'b1; instr_address = 32'h00;
    cyc(2);
    reset = 1'b1; instr_read = 1'b0;
    #1;
    chk("rstdone_instr_wait", 32'(instr_waitrequest), 32'd1);
    chk("rstdone_data_wait", 32'(data_waitrequest), 32'd1);
    chk("rstdone_mem_read", 32'(mem_read), 32'd0);
    cyc(1);
    reset = 1'b0;
    #1;
    chk("rstdone_after_wait", 32'(instr_waitrequest), 32'd1);
    chk("rstdone_rdata_clr", instr_readdata, 32'h0);
    instr_acc(32'h10, 32'hDEADBEEF);

    // Simultaneous fetch and load: data wins, fetch follows three cycles later.
    instr_read = 1'b1; instr_address = 32'h00;
    data_read = 1'b1; data_address = 32'h20; data_byteenable = 4'hF;
    cyc(2);
    chk("sim_data_ack", 32'(data_waitrequest), 32'd0);
    chk("sim_instr_wait", 32'(instr_waitrequest), 32'd1);
    chk("sim_data_rdata", data_readdata, 32'h12345678);
    data_read = 1'b0;
    cyc(2);
    chk("sim_instr_wait4", 32'(instr_waitrequest), 32'd1);
    cyc(1);
    chk("sim_instr_ack", 32'(instr_waitrequest), 32'd0);
    chk("sim_instr_rdata", instr_readdata, 32'h04030201);
    instr_read = 1'b0;
    cyc(1);

    // Both held high across four arbitrations.
    instr_read = 1'b1; data_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(k == 0 ? 2 : 3);
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk("held_data_ack", 32'(data_waitrequest), 32'(!exp_d));
      chk("held_instr_ack", 32'(instr_waitrequest), 32'(exp_d));
    end
    instr_read = 1'b0; data_read = 1'b0;
    cyc(1);

    // Single-lane store leaves the other bytes intact.
    data_acc(1'b1, 32'h30, 4'b0001, 32'hAABBCCDD);
    chk("byte_30", 32'(ram[8'h30]), 32'hDD);
    chk("byte_31", 32'(ram[8'h31]), 32'h22);
    chk("byte_33", 32'(ram[8'h33]), 32'h44);
    data_acc(1'b0, 32'h30, 4'hF, 32'h0);
    chk("byte_readback", data_readdata, 32'h443322DD);

    // Empty byteenable write still handshakes.
    data_acc(1'b1, 32'h30, 4'b0000, 32'hFFFFFFFF);
    chk("be0_30", 32'(ram[8'h30]), 32'hDD);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
